// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: turns one load/store request into a single Avalon-style bus access.
// Define MIPS_CPU_LSU_UNALIGNED_EN to enable LWL/LWR; without it, opcodes 2 and 6 are rejected.
module mips_cpu_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_LB  = 4'd0;
  localparam logic [OPW-1:0] OP_LH  = 4'd1;
  localparam logic [OPW-1:0] OP_LWL = 4'd2;
  localparam logic [OPW-1:0] OP_LW  = 4'd3;
  localparam logic [OPW-1:0] OP_LBU = 4'd4;
  localparam logic [OPW-1:0] OP_LHU = 4'd5;
  localparam logic [OPW-1:0] OP_LWR = 4'd6;
  localparam logic [OPW-1:0] OP_SB  = 4'd8;
  localparam logic [OPW-1:0] OP_SH  = 4'd9;
  localparam logic [OPW-1:0] OP_SW  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RDATA, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  addr_q, addr_d, wdata_q, wdata_d, rt_q, rt_d;
  logic [DW-1:0]  rdata_q, rdata_d, address_q, address_d, writedata_q, writedata_d;
  logic [BEW-1:0] byteenable_q, byteenable_d;
  logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic           read_q, read_d, write_q, write_d, bus_d;

  function automatic logic op_legal(input logic [OPW-1:0] o);
    case (o)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
`ifdef MIPS_CPU_LSU_UNALIGNED_EN
      OP_LWL, OP_LWR: op_legal = 1'b1;
`else
      OP_LWL, OP_LWR: op_legal = 1'b0;
`endif
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [OPW-1:0] o, input logic [1:0] a);
    case (o)
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      OP_LW, OP_SW:         misaligned = |a;
      default:              misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [BEW-1:0] byte_en(input logic [OPW-1:0] o, input logic [1:0] a);
    case (o)
      OP_LB, OP_LBU, OP_SB: byte_en = 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default:              byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] wr_data(input logic [OPW-1:0] o, input logic [DW-1:0] w);
    case (o)
      OP_SB:   wr_data = {4{w[7:0]}};
      OP_SH:   wr_data = {2{w[15:0]}};
      default: wr_data = w;
    endcase
  endfunction

  // Lane extraction plus LWL/LWR merge with the old rt value.
  function automatic logic [DW-1:0] load_data(input logic [OPW-1:0] o, input logic [1:0] a,
                                              input logic [DW-1:0] rd, input logic [DW-1:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh_k, sh_nk;
    sh_k  = {a, 3'b000};
    sh_nk = {2'(2'd3 - a), 3'b000};
    b     = 8'(rd >> sh_k);
    h     = a[1] ? rd[31:16] : rd[15:0];
    case (o)
      OP_LB:   load_data = {{24{b[7]}}, b};
      OP_LBU:  load_data = {24'd0, b};
      OP_LH:   load_data = {{16{h[15]}}, h};
      OP_LHU:  load_data = {16'd0, h};
      OP_LWL:  load_data = (rd << sh_nk) | (rt & (32'h00FF_FFFF >> sh_k));
      OP_LWR:  load_data = (rd >> sh_k) | (rt & ~(32'hFFFF_FFFF >> sh_k));
      default: load_data = rd;
    endcase
  endfunction

  // Next-state, captured request and registered bus/status outputs.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rt_d    = rt_q;
    rdata_d = rdata_q;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          rt_d    = rt_in;
          if (!op_legal(op) || misaligned(op, addr[1:0])) begin
            state_d = S_DONE;
            error_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          state_d = op_q[3] ? S_DONE : S_RDATA;
          if (op_q[3]) rdata_d = '0;
        end
      end
      S_RDATA: begin
        rdata_d = load_data(op_q, addr_q[1:0], readdata, rt_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    bus_d        = (state_d == S_BUS);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    read_d       = bus_d && !op_d[3];
    write_d      = bus_d && op_d[3];
    address_d    = bus_d ? {addr_d[31:2], 2'b00} : '0;
    byteenable_d = bus_d ? byte_en(op_d, addr_d[1:0]) : '0;
    writedata_d  = write_d ? wr_data(op_d, wdata_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rt_q         <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rt_q         <= rt_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign rdata      = rdata_q;
  assign read       = read_q;
  assign write      = write_q;
  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu: driver pushes model expectations, negedge monitor pops at done.
module tb_mips_cpu_lsu;

  logic        clk = 1'b0;
  logic        reset, req, busy, done, error, read, write, waitrequest;
  logic [3:0]  op, byteenable;
  logic [31:0] addr, wdata, rt_in, rdata, address, writedata, readdata;

  always #5 clk = ~clk;

  mips_cpu_lsu dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata), .rt_in(rt_in),
    .busy(busy), .done(done), .error(error), .rdata(rdata), .address(address), .read(read),
    .write(write), .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  typedef struct {
    logic        err;
    logic        ld;
    logic        st;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] address;
    logic [31:0] wdata;
    int          lat;
    int          bus_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  int          negcnt = 0, req_neg = 0, bus_cnt = 0, done_cnt = 0, spurious = 0;
  logic        bus_bad = 1'b0, both_hi = 1'b0, ignore_bus = 1'b0;
  int          waits_left = 0;
  logic [31:0] cur_word = '0;
  logic        pending_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: per-lane view of the access built straight from the opcode rules.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                                 input logic [31:0] rt, input logic [31:0] word, input int waits);
    exp_t       e;
    int         k, size;
    bit         sgn, legal, unal, mrg;
    logic [7:0] m[4], r[4], wb[4], res[4], fill;
`ifdef MIPS_CPU_LSU_UNALIGNED_EN
    unal = 1'b1;
`else
    unal = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      m[i]  = word[8*i +: 8];
      r[i]  = rt[8*i +: 8];
      wb[i] = w[8*i +: 8];
    end
    k = int'(a[1:0]);
    legal = 1'b1; size = 4; sgn = 1'b0; e.ld = 1'b0; e.st = 1'b0;
    mrg = (o == 4'd2) || (o == 4'd6);
    case (o)
      4'd0:  begin size = 1; sgn = 1'b1; e.ld = 1'b1; end
      4'd1:  begin size = 2; sgn = 1'b1; e.ld = 1'b1; end
      4'd3:  begin size = 4; e.ld = 1'b1; end
      4'd4:  begin size = 1; e.ld = 1'b1; end
      4'd5:  begin size = 2; e.ld = 1'b1; end
      4'd8:  begin size = 1; e.st = 1'b1; end
      4'd9:  begin size = 2; e.st = 1'b1; end
      4'd11: begin size = 4; e.st = 1'b1; end
      4'd2, 4'd6: begin size = 4; e.ld = 1'b1; legal = unal; end
      default: legal = 1'b0;
    endcase
    e.err = !legal || (size == 2 && (k % 2) != 0) || (size == 4 && !mrg && k != 0);
    e.address = {a[31:2], 2'b00};
    for (int j = 0; j < 4; j++) begin
      e.be[j] = (size == 4) ? 1'b1 : (j >= k && j < k + size);
      e.wdata[8*j +: 8] = e.st ? wb[j % size] : 8'h00;
    end
    fill = (sgn && (size < 4) && m[(k + size - 1) % 4][7]) ? 8'hFF : 8'h00;
    for (int j = 0; j < 4; j++) begin
      if (o == 4'd2)      res[j] = (j >= 3 - k) ? m[(j - (3 - k)) % 4] : r[j];
      else if (o == 4'd6) res[j] = (j <= 3 - k) ? m[(j + k) % 4] : r[j];
      else                res[j] = (j < size) ? m[(k + j) % 4] : fill;
      e.rdata[8*j +: 8] = res[j];
    end
    if (e.err) begin
      e.rdata = '0; e.ld = 1'b0; e.st = 1'b0; e.lat = 1; e.bus_cyc = 0;
    end else begin
      e.lat = (e.st ? 2 : 3) + waits;
      e.bus_cyc = waits + 1;
    end
    return e;
  endfunction

  // Bus slave: waitrequest count per access, readdata one cycle after acceptance.
  always @(negedge clk) begin
    if (pending_rd) begin
      readdata   = cur_word;
      pending_rd = 1'b0;
    end else begin
      readdata = $urandom;
    end
    if (read || write) begin
      if (waits_left > 0) begin
        waitrequest = 1'b1;
        waits_left--;
      end else begin
        waitrequest = 1'b0;
        pending_rd  = read;
      end
    end else begin
      waitrequest = 1'($urandom);
    end
  end

  // Monitor: watches strobes each cycle and retires one scoreboard entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    negcnt++;
    if (req && !busy && !reset) req_neg = negcnt;
    if (read || write) begin
      if (read && write) both_hi = 1'b1;
      if (!ignore_bus) begin
        if (sb.size() == 0) spurious++;
        else begin
          e = sb[0];
          bus_cnt++;
          if (read !== e.ld || write !== e.st || address !== e.address ||
              byteenable !== e.be || (write && writedata !== e.wdata)) bus_bad = 1'b1;
        end
      end
    end
    if (done) begin
      if (sb.size() == 0) spurious++;
      else begin
        e = sb.pop_front();
        chk("error", 32'(error), 32'(e.err));
        if (e.err || e.ld) chk("rdata", rdata, e.rdata);
        chk("latency", 32'(negcnt - req_neg), 32'(e.lat));
        chk("bus_cycles", 32'(bus_cnt), 32'(e.bus_cyc));
        chk("bus_fields", 32'(bus_bad), 32'd0);
        chk("rw_exclusive", 32'(both_hi), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd1);
        bus_cnt = 0; bus_bad = 1'b0; both_hi = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] rt, input logic [31:0] word, input int waits);
    int start, c;
    sb.push_back(model(o, a, w, rt, word, waits));
    @(posedge clk); #1;
    cur_word = word; waits_left = waits;
    req = 1'b1; op = o; addr = a; wdata = w; rt_in = rt;
    start = done_cnt;
    @(posedge clk); #1;
    req = 1'b0; op = 4'($urandom); addr = $urandom; wdata = $urandom; rt_in = $urandom;
    c = 0;
    while (done_cnt == start && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    if (done_cnt == start) begin
      n_chk++;
      $display("FAIL timeout: no done within %0d cycles, op %0d addr 0x%08h", c, o, a);
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0; rt_in = '0;
    waitrequest = 1'b0; readdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    reset = 1'b0;

    issue(4'd11, 32'hBFC0_0010, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
    issue(4'd0,  32'hBFC0_0022, 32'h0, 32'h0, 32'h80FF_7F01, 0);
    issue(4'd4,  32'hBFC0_0022, 32'h0, 32'h0, 32'h80FF_7F01, 0);
    issue(4'd1,  32'hBFC0_0022, 32'h0, 32'h0, 32'h80FF_7F01, 1);
    issue(4'd9,  32'hBFC0_0011, 32'h1234_5678, 32'h0, 32'h0, 0);
    issue(4'd3,  32'hBFC0_0020, 32'h0, 32'h0, 32'h1357_9BDF, 3);
    issue(4'd2,  32'hBFC0_0021, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
    issue(4'd6,  32'hBFC0_0021, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 2);
    issue(4'd8,  32'h0000_0003, 32'h0000_00A5, 32'h0, 32'h0, 0);
    issue(4'd7,  32'h0000_0000, 32'h0, 32'h0, 32'h0, 0);

    // Reset mid-BUS with waitrequest held: the access must vanish without a done pulse.
    @(posedge clk); #1;
    ignore_bus = 1'b1; waits_left = 20;
    req = 1'b1; op = 4'd3; addr = 32'hBFC0_0040;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_bus_read_before", 32'(read), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; waits_left = 0; pending_rd = 1'b0;
    chk("rst_mid_bus_read", 32'(read), 32'd0);
    chk("rst_mid_bus_busy", 32'(busy), 32'd0);
    chk("rst_mid_bus_done", 32'(done), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_bus_idle", 32'(busy), 32'd0);
    ignore_bus = 1'b0;

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      issue(4'($urandom_range(0, 15)), a, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("spurious_events", 32'(spurious), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_cpu_lsu.md
MIPS_CPU_LSU -- requirements
Module: mips_cpu_lsu

Interface
REQ-001 SHALL have parameter none; all behaviour fixed except the REQ-030 macro.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: req  in  1  start access; op  in  4  MIPS opcode[3:0] (0 LB,1 LH,2 LWL,3 LW,4 LBU,5 LHU,6 LWR,8 SB,9 SH,11 SW).
REQ-004 SHALL have ports: addr  in  32  byte address; wdata  in  32  store source (rt); rt_in  in  32  old rt for LWL/LWR merge.
REQ-005 SHALL have ports: busy  out  1  access in progress; done  out  1  one-cycle completion; error  out  1  with done, access rejected; rdata  out  32  load result, valid while done.
REQ-006 SHALL have bus ports: address  out  32; read  out  1; write  out  1; waitrequest  in  1; writedata  out  32; byteenable  out  4; readdata  in  32.

Function
REQ-007 SHALL implement states IDLE, BUS, RDATA, DONE; busy = state != IDLE.
REQ-008 IDLE: req=1 at an edge SHALL register op, addr, wdata, rt_in and go to BUS (or DONE with error per REQ-015); req ignored in all other states.
REQ-009 BUS: SHALL hold read (loads) or write (stores) high with address, byteenable, writedata stable until an edge with waitrequest=0.
REQ-010 BUS accepted: store -> DONE; load -> RDATA.
REQ-011 RDATA: SHALL capture readdata (valid exactly one cycle after acceptance) and go to DONE.
REQ-012 DONE: done=1 for exactly one cycle, rdata/error valid, then IDLE; read/write low.
REQ-013 Latency with waitrequest=0: store done 2 cycles after req edge, load done 3 cycles; each waitrequest cycle adds one.
REQ-014 address SHALL be {addr[31:2],2'b00}; lane n = bits [8n+7:8n], selected by addr[1:0]=n (little-endian).
REQ-015 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) or undefined op: no bus strobe, straight to DONE, error=1, rdata=0.
REQ-016 byteenable: B ops one-hot lane addr[1:0]; H ops 0011 (addr[1]=0) / 1100; W, LWL, LWR 1111.
REQ-017 writedata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-018 rdata: LB/LH sign-extended selected byte/half; LBU/LHU zero-extended; LW readdata.
REQ-019 read and write SHALL never be high together; both low outside BUS.

Reset
REQ-020 reset=1 at an edge SHALL force IDLE, clear registered inputs, regardless of state (including mid-BUS with waitrequest high).
REQ-021 Reset values: busy 0, done 0, error 0, rdata 0, read 0, write 0, address 0, byteenable 0, writedata 0.
REQ-022 Pending readdata after reset SHALL be discarded; req sampled only on the first non-reset edge.

Configuration
REQ-030 Macro MIPS_CPU_LSU_UNALIGNED_EN defined: LWL/LWR supported, k=addr[1:0]; LWL rdata = (readdata << 8(3-k)) | (rt_in & low (3-k) bytes); LWR rdata = (readdata >> 8k) | (rt_in & high k bytes).
REQ-031 Macro undefined: ops 2 and 6 treated as undefined per REQ-015 (error, no bus access).

Verification
REQ-040 SW addr 0xBFC00010, wdata 0xDEADBEEF, waitrequest 0 -> write 1 cycle, byteenable 1111, address 0xBFC00010, done 2 cycles after req.
REQ-041 Memory word 0x80FF7F01 at 0xBFC00020: LB addr 0x...22 -> rdata 0xFFFFFFFF; LBU same -> 0x000000FF; LH 0x...22 -> 0xFFFF80FF; byteenable 0100/0100/1100.
REQ-042 SH addr 0xBFC00011 -> error=1 with done 1 cycle after req, read/write never asserted.
REQ-043 LW with waitrequest held 3 cycles -> read held 4 cycles, address stable, done 6 cycles after req, rdata = readdata.
REQ-044 Reset asserted during BUS with waitrequest high -> next cycle read 0, busy 0, done never pulses.
REQ-045 With macro: word 0x44332211, rt_in 0xAABBCCDD, LWL k=1 -> 0x2211CCDD, LWR k=1 -> 0xAA443322; without macro -> error=1.
